dig_scheduler: RTL and testbench

//   Shares one digging resource (the "shovel") among N lemming FSMs.

---
 rtl/dig_scheduler.sv | 134 +++++++++++++
 tb/tb_dig_scheduler.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dig_scheduler.sv
// Round-robin arbiter sharing one digging shovel among N lemmings.
// A grant is held until ground loss, request drop or MAX_DIG cycles, followed by a cooldown.
module dig_scheduler #(
    parameter int N        = 4,
    parameter int MAX_DIG  = 8,
    parameter int COOLDOWN = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         dig_req,
    input  logic [N-1:0]         ground,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout
);

    localparam int IDW = $clog2(N);
    localparam int DCW = $clog2(MAX_DIG + 1);
    localparam int CCW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam int unsigned NU = N;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        COOL  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] last_q, last_d;
    logic [DCW-1:0] dig_cnt_q, dig_cnt_d;
    logic [CCW-1:0] cool_cnt_q, cool_cnt_d;
    logic           done_q, done_d;
    logic           timeout_q, timeout_d;

    logic [N-1:0]   elig;
    logic [IDW-1:0] sel;
    logic           found;
    int unsigned    cand;

    assign elig = dig_req & ground;

    // First eligible index strictly after last_q, wrapping modulo N.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned i = 0; i < NU; i++) begin
            cand = 32'(last_q) + 1 + i;
            if (cand >= NU) cand = cand - NU;
            if (!found && elig[IDW'(cand)]) begin
                found = 1'b1;
                sel   = IDW'(cand);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        id_d       = id_q;
        last_d     = last_q;
        dig_cnt_d  = dig_cnt_q;
        cool_cnt_d = cool_cnt_q;
        done_d     = 1'b0;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d   = '0;
                    grant_d[sel] = 1'b1;
                    id_d      = sel;
                    last_d    = sel;
                    dig_cnt_d = '0;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                if (!ground[id_q] || !dig_req[id_q] || dig_cnt_q == DCW'(MAX_DIG - 1)) begin
                    grant_d    = '0;
                    cool_cnt_d = '0;
                    state_d    = (COOLDOWN > 0) ? COOL : IDLE;
                    if (!ground[id_q])       done_d    = 1'b1;
                    else if (dig_req[id_q])  timeout_d = 1'b1;
                end else begin
                    dig_cnt_d = dig_cnt_q + 1'b1;
                end
            end
            COOL: begin
                if (cool_cnt_q == CCW'(COOLDOWN - 1)) begin
                    state_d = IDLE;
                end else begin
                    cool_cnt_d = cool_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            id_q       <= '0;
            last_q     <= IDW'(N - 1);
            dig_cnt_q  <= '0;
            cool_cnt_q <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            id_q       <= id_d;
            last_q     <= last_d;
            dig_cnt_q  <= dig_cnt_d;
            cool_cnt_q <= cool_cnt_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = id_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_dig_scheduler.sv
// Directed bench for dig_scheduler with N=4, MAX_DIG=8, COOLDOWN=2.
module tb_dig_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] dig_req;
    logic [3:0] ground;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       done;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;

    dig_scheduler #(.N(4), .MAX_DIG(8), .COOLDOWN(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .dig_req  (dig_req),
        .ground   (ground),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Waits (bounded) for a grant, then checks it lasts 8 cycles and ends in a timeout.
    task automatic expect_timed_grant(input string tag, input logic [3:0] exp_g, input logic [1:0] exp_id);
        for (int i = 0; i < 10 && grant == 4'b0; i++) tick();
        check({tag, " grant"}, grant, exp_g);
        check({tag, " id"}, grant_id, exp_id);
        for (int k = 1; k < 8; k++) begin
            tick();
            check({tag, " hold"}, grant, exp_g);
        end
        tick();
        check({tag, " release"}, grant, 4'b0);
        check({tag, " timeout"}, timeout, 1'b1);
    endtask

    initial begin
        dig_req = 4'b0;
        ground  = 4'b0;
        do_reset();
        check("rst grant", grant, 4'b0);
        check("rst id", grant_id, 2'd0);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst timeout", timeout, 1'b0);

        // 1. single requester, timeout, 3-cycle gap, re-grant
        dig_req = 4'b0001;
        ground  = 4'b1111;
        tick();
        check("t1 grant", grant, 4'b0001);
        check("t1 busy", busy, 1'b1);
        for (int k = 1; k < 8; k++) begin
            tick();
            check("t1 hold", grant, 4'b0001);
            check("t1 no timeout", timeout, 1'b0);
        end
        tick();
        check("t1 release", grant, 4'b0);
        check("t1 timeout", timeout, 1'b1);
        check("t1 cool busy", busy, 1'b1);
        tick();
        check("t1 pulse width", timeout, 1'b0);
        check("t1 cool grant", grant, 4'b0);
        tick();
        check("t1 idle busy", busy, 1'b0);
        check("t1 idle grant", grant, 4'b0);
        tick();
        check("t1 regrant", grant, 4'b0001);

        // 2. round robin from reset
        dig_req = 4'b1111;
        do_reset();
        expect_timed_grant("rr0", 4'b0001, 2'd0);
        expect_timed_grant("rr1", 4'b0010, 2'd1);
        expect_timed_grant("rr2", 4'b0100, 2'd2);
        expect_timed_grant("rr3", 4'b1000, 2'd3);
        expect_timed_grant("rr4", 4'b0001, 2'd0);

        // 3. fall-through after 3 granted cycles
        dig_req = 4'b0100;
        do_reset();
        tick();
        check("t3 grant", grant, 4'b0100);
        check("t3 id", grant_id, 2'd2);
        tick();
        tick();
        ground = 4'b1011;
        tick();
        check("t3 release", grant, 4'b0);
        check("t3 done", done, 1'b1);
        check("t3 timeout", timeout, 1'b0);
        tick();
        check("t3 done width", done, 1'b0);

        // 4. ground loss on the same edge as the final count
        ground  = 4'b1111;
        dig_req = 4'b0001;
        do_reset();
        tick();
        for (int k = 1; k < 8; k++) tick();
        check("t4 last cycle", grant, 4'b0001);
        ground = 4'b1110;
        tick();
        check("t4 release", grant, 4'b0);
        check("t4 done", done, 1'b1);
        check("t4 timeout", timeout, 1'b0);

        // 5. eligibility filter, abort, pending request picked up on ground rise
        dig_req = 4'b0011;
        ground  = 4'b0010;
        do_reset();
        tick();
        check("t5 grant", grant, 4'b0010);
        check("t5 id", grant_id, 2'd1);
        tick();
        check("t5 hold", grant, 4'b0010);
        dig_req = 4'b0001;
        tick();
        check("t5 abort grant", grant, 4'b0);
        check("t5 abort done", done, 1'b0);
        check("t5 abort timeout", timeout, 1'b0);
        check("t5 abort busy", busy, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t5 skipped", grant, 4'b0);
        end
        ground = 4'b0011;
        tick();
        check("t5 pickup", grant, 4'b0001);
        check("t5 pickup id", grant_id, 2'd0);

        // 6. reset at granted cycle 4 restores priority to lemming 0
        dig_req = 4'b1111;
        ground  = 4'b1111;
        tick();
        tick();
        tick();
        check("t6 cycle4", grant, 4'b0001);
        reset = 1'b1;
        tick();
        check("t6 rst grant", grant, 4'b0);
        check("t6 rst busy", busy, 1'b0);
        check("t6 rst id", grant_id, 2'd0);
        check("t6 rst timeout", timeout, 1'b0);
        reset = 1'b0;
        tick();
        check("t6 first", grant, 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
